// File: rtl/fir_pkg.sv
// Shared constants and sample type for the FIR datapath and its output formatter.
package fir_pkg;

    localparam int FIR_IN_WIDTH  = 16;
    localparam int FIR_OUT_WIDTH = 38;
    localparam int FMT_OUT_WIDTH = 16;
    localparam int FMT_SHIFT     = 15;

    typedef logic signed [FMT_OUT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_out_formatter_if.sv
// Stream/status bundle between the FIR output formatter and its neighbours.
// master: the side driving FIR results in and consuming samples out.
// slave:  the formatter itself.
interface fir_out_formatter_if
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_OUT_WIDTH,
    parameter int OUT_WIDTH = FMT_OUT_WIDTH,
    parameter int DEPTH     = 4
) ();

    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_ready;
    logic [$clog2(DEPTH):0]      level;
    logic                        drop_flag;
    logic                        sat_flag;
    logic                        clr_flags;

    modport master (
        output in_valid, in_data, out_ready, clr_flags,
        input  out_valid, out_data, level, drop_flag, sat_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_flags,
        output out_valid, out_data, level, drop_flag, sat_flag
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO for formatted samples. Full/empty come from the
// occupancy counter; a push into a full FIFO is accepted when a pop frees
// the slot in the same cycle. Head entry is presented combinationally.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FMT_OUT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage, pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/fir_out_formatter.sv
// FIR output formatter: round-half-up of the wide FIR result to a 16-bit
// sample, one register stage, then a small FIFO on a valid/ready stream.
// Sticky drop flag on FIFO overflow.
// Build option FIR_OUT_SAT_EN: clip out-of-range samples and raise a sticky
// sat_flag; without it the sample wraps and sat_flag is tied low.
module fir_out_formatter
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_OUT_WIDTH,
    parameter int OUT_WIDTH = FMT_OUT_WIDTH,
    parameter int SHIFT     = FMT_SHIFT,
    parameter int DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    fir_out_formatter_if.slave  bus
);

    localparam int SUM_W = IN_WIDTH + 1;
    localparam int SH_W  = SUM_W - SHIFT;
    localparam logic [SUM_W-1:0] ROUND_C = SUM_W'(1) << (SHIFT - 1);

    logic signed [SUM_W-1:0]     w_sum;
    logic signed [SH_W-1:0]      w_shifted;
    logic signed [OUT_WIDTH-1:0] w_fmt;
    logic                        w_out_valid;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_drop;
    logic                        w_unused;
    logic                        r_s1_valid;
    logic signed [OUT_WIDTH-1:0] r_s1_data;
    logic                        r_drop_flag;

    // One extra bit of headroom so adding the half-LSB can never overflow.
    assign w_sum     = {bus.in_data[IN_WIDTH-1], bus.in_data} + ROUND_C;
    assign w_shifted = w_sum[SUM_W-1:SHIFT];

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-(2**(OUT_WIDTH-1)));

    logic w_clip;
    logic r_sat_flag;

    // Clip to the signed output range, flagging every clipped result.
    always_comb begin
        w_fmt  = w_shifted[OUT_WIDTH-1:0];
        w_clip = 1'b0;
        if (w_shifted > SAT_MAX) begin
            w_fmt  = SAT_MAX[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_fmt  = SAT_MIN[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end

    // Sticky saturation flag; a clear wins over a clip in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
        end else if (bus.clr_flags) begin
            r_sat_flag <= 1'b0;
        end else if (bus.in_valid && w_clip) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign bus.sat_flag = r_sat_flag;
    assign w_unused     = ^w_sum[SHIFT-1:0];
`else
    assign w_fmt        = w_shifted[OUT_WIDTH-1:0];
    assign bus.sat_flag = 1'b0;
    assign w_unused     = ^{w_sum[SHIFT-1:0], w_shifted[SH_W-1:OUT_WIDTH]};
`endif

    // Stage-1 register: holds the formatted sample for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data <= w_fmt;
            end
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_data),
        .i_pop   (bus.out_ready),
        .o_data  (bus.out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.level)
    );

    assign w_out_valid   = !w_empty;
    assign bus.out_valid = w_out_valid;
    // A full FIFO still takes the write when the consumer pops the same cycle.
    assign w_drop        = r_s1_valid && w_full && !(w_out_valid && bus.out_ready);

    // Sticky drop flag; a clear wins over a drop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_flag <= 1'b0;
        end else if (bus.clr_flags) begin
            r_drop_flag <= 1'b0;
        end else if (w_drop) begin
            r_drop_flag <= 1'b1;
        end
    end

    assign bus.drop_flag = r_drop_flag;

endmodule

// File: tb/tb_fir_out_formatter.sv
// Scoreboard bench for fir_out_formatter: a cycle-level reference model
// (queues + plain arithmetic rounding) pushes expected samples; a negedge
// monitor pops and compares whenever the DUT presents a sample that is taken.
module tb_fir_out_formatter;
    import fir_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_out_formatter_if #(
        .IN_WIDTH (FIR_OUT_WIDTH),
        .OUT_WIDTH(FMT_OUT_WIDTH),
        .DEPTH    (DEPTH)
    ) bus ();

    fir_out_formatter #(
        .IN_WIDTH (FIR_OUT_WIDTH),
        .OUT_WIDTH(FMT_OUT_WIDTH),
        .SHIFT    (FMT_SHIFT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int      total = 0;
    int      bad   = 0;
    sample_t sb[$];
    sample_t mq[$];
    bit      m_pend = 1'b0;
    sample_t m_s1 = '0;
    bit      m_drop = 1'b0;
    bit      m_sat = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round half toward +inf as floor((x + 2^14) / 2^15), then clip or wrap.
    function automatic sample_t ref_fmt(input longint x, output bit sat);
        longint q;
        longint r;
        q = x + 64'sd16384;
        if (q >= 0) r = q / 32768;
        else        r = -((-q + 32767) / 32768);
        sat = 1'b0;
`ifdef FIR_OUT_SAT_EN
        if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
        end
`endif
        return sample_t'(r);
    endfunction

    // Reference model: FIFO contents as a queue, stage 1 as a pending sample.
    always @(posedge clk) begin
        int      sz;
        bit      pop;
        bit      dev;
        bit      sev;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_pend = 1'b0;
            m_drop = 1'b0;
            m_sat  = 1'b0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && bus.out_ready;
            if (pop) void'(mq.pop_front());
            dev = 1'b0;
            if (m_pend) begin
                if (sz < DEPTH || pop) begin
                    mq.push_back(m_s1);
                    sb.push_back(m_s1);
                end else begin
                    dev = 1'b1;
                end
            end
            sev = 1'b0;
            if (bus.in_valid) m_s1 = ref_fmt(longint'(bus.in_data), sev);
            m_pend = bus.in_valid;
            if (bus.clr_flags) begin
                m_drop = 1'b0;
                m_sat  = 1'b0;
            end else begin
                if (dev) m_drop = 1'b1;
                if (sev) m_sat  = 1'b1;
            end
        end
    end

    // Monitor: status every cycle, data on every accepted transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", longint'(bus.out_valid), 0);
            check("rst_out_data",  longint'(bus.out_data),  0);
            check("rst_level",     longint'(bus.level),     0);
            check("rst_drop_flag", longint'(bus.drop_flag), 0);
            check("rst_sat_flag",  longint'(bus.sat_flag),  0);
        end else begin
            check("out_valid", longint'(bus.out_valid), longint'(mq.size() > 0));
            check("level",     longint'(bus.level),     longint'(mq.size()));
            check("drop_flag", longint'(bus.drop_flag), longint'(m_drop));
            check("sat_flag",  longint'(bus.sat_flag),  longint'(m_sat));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty actual=unexpected_sample required=no_sample at %0t", $time);
                end else begin
                    check("out_data", longint'(bus.out_data), longint'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit v, input logic signed [37:0] d, input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_flags = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [37:0] rand_data();
        int     mode;
        longint t;
        mode = int'($urandom_range(0, 2));
        if (mode == 0) begin
            t = longint'({$urandom(), $urandom()});
        end else if (mode == 1) begin
            t = longint'($urandom_range(0, 262143)) - 131072;
        end else begin
            t = (longint'($urandom_range(0, 131071)) - 65536) * 32768
                + longint'($urandom_range(0, 32767));
        end
        return 38'(t);
    endfunction

    initial begin
        longint rnd_vals [5];
        bit     v;
        bit     rdy;
        bit     clr;
        rnd_vals = '{32768, 16384, 16383, -16384, -16385};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clr_flags = 1'b0;
        rst_n         = 1'b0;

        // Reset held with in_valid toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = rand_data();
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Rounding boundaries.
        foreach (rnd_vals[i]) begin
            step(1'b1, 38'(rnd_vals[i]), 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Extremes: clip (or wrap without the saturation option).
        step(1'b1, 38'sh1F_FFFF_FFFF, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 38'sh20_0000_0000, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);

        // Overflow: five samples with no consumer, then clear.
        repeat (5) step(1'b1, rand_data(), 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Full FIFO: write lands in the same cycle as a pop.
        step(1'b1, rand_data(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);

        // Full FIFO: drop coincides with clear, clear wins.
        step(1'b1, rand_data(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        repeat (8) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst_n = 1'b0;
                repeat (3) step(1'b1, rand_data(), 1'b1, 1'b0);
                rst_n = 1'b1;
            end
            v   = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            step(v, rand_data(), rdy, clr);
        end

        // FIR-like spacing with a sporadically stalling consumer.
        for (int n = 0; n < 40; n++) begin
            step(1'b1, rand_data(), 1'b0, 1'b0);
            repeat (65) step(1'b0, '0, ($urandom_range(0, 1) == 1), 1'b0);
        end

        repeat (10) step(1'b0, '0, 1'b1, 1'b0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain actual=%0d required=0 samples left", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
